// File: rtl/vram_arbiter.sv
// vram_arbiter: shares one single-port synchronous video RAM between the tile
// renderer fetch path and the CPU bus. The renderer wins inside the visible
// frame, the CPU wins during blanking, and a starvation counter forces a CPU
// slot when the renderer has kept a CPU request waiting too long.
module vram_arbiter #(
    parameter int AW       = 16,
    parameter int DW       = 8,
    parameter int MAX_WAIT = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          frame_active,
    input  logic          vid_req,
    input  logic [AW-1:0] vid_addr,
    output logic          vid_gnt,
    output logic          vid_rvalid,
    output logic [DW-1:0] vid_rdata,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_gnt,
    output logic          cpu_rvalid,
    output logic [DW-1:0] cpu_rdata,
    output logic          ram_en,
    output logic          ram_we,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_wdata,
    input  logic [DW-1:0] ram_rdata
);

    localparam int CW = $clog2(MAX_WAIT + 1);

    typedef enum logic [1:0] {
        BLANK  = 2'd0,
        ACTIVE = 2'd1,
        FORCE  = 2'd2
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] wait_cnt;
    logic [CW-1:0] wait_nxt;
    logic          force_trig;

    logic          p1_valid;
    logic          p1_cpu;
    logic          p1_read;
    logic          p2_valid;
    logic          p2_cpu;
    logic          p2_read;

    logic [DW-1:0] vid_hold;
    logic [DW-1:0] cpu_hold;

    // Grant decode: priority depends on the registered state; nothing is granted while reset is held.
    always_comb begin
        vid_gnt = 1'b0;
        cpu_gnt = 1'b0;
        if (!rst) begin
            case (state)
                BLANK: begin
                    cpu_gnt = cpu_req;
                    vid_gnt = vid_req & ~cpu_req;
                end
                ACTIVE: begin
                    vid_gnt = vid_req;
                    cpu_gnt = cpu_req & ~vid_req;
                end
                FORCE: begin
                    cpu_gnt = cpu_req;
                    vid_gnt = 1'b0;
                end
                default: begin
                    vid_gnt = 1'b0;
                    cpu_gnt = 1'b0;
                end
            endcase
        end
    end

    // Starvation counter update; the forced slot fires once the next count reaches MAX_WAIT-1.
    always_comb begin
        wait_nxt   = wait_cnt;
        force_trig = 1'b0;
        if (!cpu_req || cpu_gnt) begin
            wait_nxt = '0;
        end else if (wait_cnt != CW'(MAX_WAIT)) begin
            wait_nxt = wait_cnt + CW'(1);
        end
        force_trig = cpu_req && !cpu_gnt && (wait_nxt >= CW'(MAX_WAIT - 1));
    end

    // Next-state logic: frame_active picks the priority mode, FORCE always lasts a single cycle.
    always_comb begin
        state_nxt = state;
        case (state)
            BLANK: begin
                state_nxt = frame_active ? ACTIVE : BLANK;
            end
            ACTIVE: begin
                if (!frame_active) begin
                    state_nxt = BLANK;
                end else if (force_trig) begin
                    state_nxt = FORCE;
                end
            end
            FORCE: begin
                state_nxt = frame_active ? ACTIVE : BLANK;
            end
            default: begin
                state_nxt = BLANK;
            end
        endcase
    end

    // State and starvation counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= BLANK;
            wait_cnt <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_nxt;
        end
    end

    // RAM command register: the granted requester's access is presented one cycle after the grant.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ram_en    <= 1'b0;
            ram_we    <= 1'b0;
            ram_addr  <= '0;
            ram_wdata <= '0;
        end else begin
            ram_en <= vid_gnt | cpu_gnt;
            if (cpu_gnt) begin
                ram_we    <= cpu_we;
                ram_addr  <= cpu_addr;
                ram_wdata <= cpu_wdata;
            end else if (vid_gnt) begin
                ram_we   <= 1'b0;
                ram_addr <= vid_addr;
            end else begin
                ram_we <= 1'b0;
            end
        end
    end

    // Owner pipe: tracks who issued each access so the read data returns to the right side.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p1_valid <= 1'b0;
            p1_cpu   <= 1'b0;
            p1_read  <= 1'b0;
            p2_valid <= 1'b0;
            p2_cpu   <= 1'b0;
            p2_read  <= 1'b0;
        end else begin
            p1_valid <= vid_gnt | cpu_gnt;
            p1_cpu   <= cpu_gnt;
            p1_read  <= cpu_gnt ? ~cpu_we : vid_gnt;
            p2_valid <= p1_valid;
            p2_cpu   <= p1_cpu;
            p2_read  <= p1_read;
        end
    end

    assign vid_rvalid = p2_valid & ~p2_cpu & p2_read;
    assign cpu_rvalid = p2_valid &  p2_cpu & p2_read;

    // Read data holding registers so each side keeps its last returned value between reads.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vid_hold <= '0;
            cpu_hold <= '0;
        end else begin
            if (vid_rvalid) begin
                vid_hold <= ram_rdata;
            end
            if (cpu_rvalid) begin
                cpu_hold <= ram_rdata;
            end
        end
    end

    assign vid_rdata = vid_rvalid ? ram_rdata : vid_hold;
    assign cpu_rdata = cpu_rvalid ? ram_rdata : cpu_hold;

endmodule

// File: tb/tb_vram_arbiter.sv
// tb_vram_arbiter: directed bench for vram_arbiter with a behavioural RAM and
// a read-data scoreboard per requester.
module tb_vram_arbiter;

    localparam int AW       = 16;
    localparam int DW       = 8;
    localparam int MAX_WAIT = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          frame_active;
    logic          vid_req;
    logic [AW-1:0] vid_addr;
    logic          vid_gnt;
    logic          vid_rvalid;
    logic [DW-1:0] vid_rdata;
    logic          cpu_req;
    logic          cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic          cpu_gnt;
    logic          cpu_rvalid;
    logic [DW-1:0] cpu_rdata;
    logic          ram_en;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] ram_rdata = '0;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] ram_mem [0:65535];
    logic [DW-1:0] written [logic [AW-1:0]];
    logic [DW-1:0] vid_exp_q [$];
    logic [DW-1:0] cpu_exp_q [$];

    int            step_kind [8] = '{0, 1, 0, 2, 0, 1, 0, 1};
    logic [AW-1:0] step_addr [8] = '{16'h0100, 16'h0200, 16'h0101, 16'h0101,
                                     16'h0101, 16'h0101, 16'h1234, 16'h0010};
    logic [DW-1:0] step_data [8] = '{8'h00, 8'h00, 8'h00, 8'hC3,
                                     8'h00, 8'h00, 8'h00, 8'h00};

    always #5 clk = ~clk;

    vram_arbiter #(
        .AW       (AW),
        .DW       (DW),
        .MAX_WAIT (MAX_WAIT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .frame_active (frame_active),
        .vid_req      (vid_req),
        .vid_addr     (vid_addr),
        .vid_gnt      (vid_gnt),
        .vid_rvalid   (vid_rvalid),
        .vid_rdata    (vid_rdata),
        .cpu_req      (cpu_req),
        .cpu_we       (cpu_we),
        .cpu_addr     (cpu_addr),
        .cpu_wdata    (cpu_wdata),
        .cpu_gnt      (cpu_gnt),
        .cpu_rvalid   (cpu_rvalid),
        .cpu_rdata    (cpu_rdata),
        .ram_en       (ram_en),
        .ram_we       (ram_we),
        .ram_addr     (ram_addr),
        .ram_wdata    (ram_wdata),
        .ram_rdata    (ram_rdata)
    );

    // Behavioural single-port synchronous RAM with one cycle read latency.
    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) ram_mem[ram_addr] <= ram_wdata;
            else        ram_rdata <= ram_mem[ram_addr];
        end
    end

    function automatic logic [DW-1:0] init_pat(input logic [AW-1:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h3C;
    endfunction

    function automatic logic [DW-1:0] exp_data(input logic [AW-1:0] a);
        if (written.exists(a)) return written[a];
        return init_pat(a);
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Drives one cycle of inputs just after the rising edge and returns on the falling edge.
    task automatic applyStimulus(input logic fa, input logic v_req, input logic [AW-1:0] v_addr,
                                 input logic c_req, input logic c_we, input logic [AW-1:0] c_addr,
                                 input logic [DW-1:0] c_wdata);
        @(posedge clk);
        #1;
        frame_active = fa;
        vid_req      = v_req;
        vid_addr     = v_addr;
        cpu_req      = c_req;
        cpu_we       = c_we;
        cpu_addr     = c_addr;
        cpu_wdata    = c_wdata;
        @(negedge clk);
    endtask

    // Checks the grants of the current cycle and records what the granted access should return.
    task automatic checkGrants(input string tag, input logic exp_v, input logic exp_c);
        checkOutput({tag, "_vid_gnt"}, vid_gnt, exp_v);
        checkOutput({tag, "_cpu_gnt"}, cpu_gnt, exp_c);
        if (exp_v) vid_exp_q.push_back(exp_data(vid_addr));
        if (exp_c) begin
            if (cpu_we) written[cpu_addr] = cpu_wdata;
            else        cpu_exp_q.push_back(exp_data(cpu_addr));
        end
    endtask

    // Scoreboard: every read return must match the oldest outstanding expectation of its owner.
    always @(negedge clk) begin
        if (vid_rvalid) begin
            if (vid_exp_q.size() == 0) checkOutput("vid_rvalid_spurious", vid_rvalid, 0);
            else                       checkOutput("vid_rdata_order", vid_rdata, vid_exp_q.pop_front());
        end
        if (cpu_rvalid) begin
            if (cpu_exp_q.size() == 0) checkOutput("cpu_rvalid_spurious", cpu_rvalid, 0);
            else                       checkOutput("cpu_rdata_order", cpu_rdata, cpu_exp_q.pop_front());
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed sequence.
    initial begin
        logic [AW-1:0] prev_addr;

        rst          = 1'b1;
        frame_active = 1'b0;
        vid_req      = 1'b1;
        vid_addr     = 16'h0050;
        cpu_req      = 1'b1;
        cpu_we       = 1'b0;
        cpu_addr     = 16'h0020;
        cpu_wdata    = 8'h00;
        for (int i = 0; i < 65536; i++) ram_mem[i] = init_pat(16'(i));
        ram_mem[16'h0010] = 8'hA5;
        written[16'h0010] = 8'hA5;

        // 1: outputs quiet under reset even with both requests high
        repeat (3) @(negedge clk);
        checkOutput("rst_vid_gnt", vid_gnt, 0);
        checkOutput("rst_cpu_gnt", cpu_gnt, 0);
        checkOutput("rst_ram_en", ram_en, 0);
        checkOutput("rst_ram_we", ram_we, 0);
        checkOutput("rst_ram_addr", ram_addr, 0);
        checkOutput("rst_ram_wdata", ram_wdata, 0);
        checkOutput("rst_vid_rvalid", vid_rvalid, 0);
        checkOutput("rst_cpu_rvalid", cpu_rvalid, 0);
        checkOutput("rst_vid_rdata", vid_rdata, 0);
        checkOutput("rst_cpu_rdata", cpu_rdata, 0);

        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checkGrants("t1_release", 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 8'h0);
        checkGrants("t1_idle", 1'b0, 1'b0);
        checkOutput("t1_ram_en", ram_en, 1);
        checkOutput("t1_ram_we", ram_we, 0);
        checkOutput("t1_ram_addr", ram_addr, 16'h0020);
        applyStimulus(1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 8'h0);
        checkOutput("t1_cpu_rvalid", cpu_rvalid, 1);
        checkOutput("t1_cpu_rdata", cpu_rdata, 8'h1C);
        checkOutput("t1_ram_en_idle", ram_en, 0);

        // 2: single renderer read in the visible frame
        applyStimulus(1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 8'h0);
        applyStimulus(1'b1, 1'b1, 16'h0010, 1'b0, 1'b0, 16'h0, 8'h0);
        checkGrants("t2_grant", 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 8'h0);
        checkOutput("t2_ram_en", ram_en, 1);
        checkOutput("t2_ram_we", ram_we, 0);
        checkOutput("t2_ram_addr", ram_addr, 16'h0010);
        checkOutput("t2_vid_rvalid_early", vid_rvalid, 0);
        applyStimulus(1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 8'h0);
        checkOutput("t2_vid_rvalid", vid_rvalid, 1);
        checkOutput("t2_vid_rdata", vid_rdata, 8'hA5);

        // 3: starved CPU write gets a forced slot after seven refusals
        for (int k = 0; k < MAX_WAIT - 1; k++) begin
            applyStimulus(1'b1, 1'b1, 16'h0040, 1'b1, 1'b1, 16'h1234, 8'h5A);
            checkGrants($sformatf("t3_wait%0d", k), 1'b1, 1'b0);
            if (k > 0) checkOutput($sformatf("t3_ram_en%0d", k), ram_en, 1);
        end
        applyStimulus(1'b1, 1'b1, 16'h0040, 1'b1, 1'b1, 16'h1234, 8'h5A);
        checkGrants("t3_force", 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b1, 16'h0040, 1'b0, 1'b0, 16'h0, 8'h0);
        checkGrants("t3_after", 1'b1, 1'b0);
        checkOutput("t3_ram_en", ram_en, 1);
        checkOutput("t3_ram_we", ram_we, 1);
        checkOutput("t3_ram_addr", ram_addr, 16'h1234);
        checkOutput("t3_ram_wdata", ram_wdata, 8'h5A);
        applyStimulus(1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 8'h0);
        checkOutput("t3_wr_no_cpu_rvalid", cpu_rvalid, 0);
        checkOutput("t3_wr_no_vid_rvalid", vid_rvalid, 0);
        checkOutput("t3_ram_we_back", ram_we, 0);
        repeat (2) applyStimulus(1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 8'h0);

        // 4: blanking gives the CPU every slot until the frame starts
        applyStimulus(1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 8'h0);
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1'b0, 1'b1, 16'h0060, 1'b1, 1'b0, 16'h1234, 8'h0);
            checkGrants($sformatf("t4_blank%0d", k), 1'b0, 1'b1);
        end
        applyStimulus(1'b1, 1'b1, 16'h0060, 1'b1, 1'b0, 16'h1234, 8'h0);
        checkGrants("t4_edge", 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b1, 16'h0060, 1'b1, 1'b0, 16'h1234, 8'h0);
        checkGrants("t4_active", 1'b1, 1'b0);
        repeat (3) applyStimulus(1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 8'h0);

        // 5: asynchronous reset kills an in-flight CPU read
        applyStimulus(1'b1, 1'b0, 16'h0, 1'b1, 1'b0, 16'h0030, 8'h0);
        checkGrants("t5_grant", 1'b0, 1'b1);
        @(posedge clk);
        #1 cpu_req = 1'b0;
        #1 rst = 1'b1;
        #1;
        checkOutput("t5_rst_ram_en", ram_en, 0);
        checkOutput("t5_rst_cpu_rvalid", cpu_rvalid, 0);
        checkOutput("t5_rst_cpu_gnt", cpu_gnt, 0);
        cpu_exp_q.delete();
        #1 rst = 1'b0;
        @(negedge clk);
        checkOutput("t5_n1_cpu_rvalid", cpu_rvalid, 0);
        applyStimulus(1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 8'h0);
        checkOutput("t5_n2_cpu_rvalid", cpu_rvalid, 0);
        checkOutput("t5_n2_cpu_rdata", cpu_rdata, 0);
        checkOutput("t5_n2_ram_en", ram_en, 0);

        // 6: alternating back-to-back grants with a write in the middle
        applyStimulus(1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 8'h0);
        prev_addr = '0;
        for (int i = 0; i < 8; i++) begin
            if (step_kind[i] == 0)
                applyStimulus(1'b1, 1'b1, step_addr[i], 1'b0, 1'b0, 16'h0, 8'h0);
            else
                applyStimulus(1'b1, 1'b0, 16'h0, 1'b1, step_kind[i] == 2, step_addr[i], step_data[i]);
            checkGrants($sformatf("t6_step%0d", i), step_kind[i] == 0, step_kind[i] != 0);
            if (i > 0) begin
                checkOutput($sformatf("t6_ram_en%0d", i), ram_en, 1);
                checkOutput($sformatf("t6_ram_addr%0d", i), ram_addr, prev_addr);
            end
            prev_addr = step_addr[i];
        end
        repeat (3) applyStimulus(1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 8'h0);
        checkOutput("vid_q_drained", vid_exp_q.size(), 0);
        checkOutput("cpu_q_drained", cpu_exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
